// File: rtl/adc_depth_sampler.sv
// ADC128S022 serial master that repeatedly converts one channel and publishes
// a box-averaged 12-bit depth sample with a wrapping update sequence count.
module adc_depth_sampler #(
  parameter int SCLK_HALF  = 25, // clk cycles per SCLK half-period, 1..255
  parameter int GAP_CYCLES = 4,  // clk cycles CS_N held high between frames, 1..255
  parameter int AVG_LOG2   = 4   // log2 of samples per average, 0..8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  chan,
  input  logic        adc_sdat,
  output logic        adc_cs_n,
  output logic        adc_saddr,
  output logic        adc_sclk,
  output logic [31:0] raw_depth,
  output logic        depth_valid
);

  // Accumulator sized so that 2**AVG_LOG2 full-scale samples never overflow.
  localparam int ACC_W = 12 + AVG_LOG2;
  // One spare bit keeps the counter non-zero width when AVG_LOG2 is 0.
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] HALF_LAST = 8'(SCLK_HALF - 1);

  typedef enum logic [1:0] {
    S_GAP,
    S_START,
    S_XFER,
    S_DONE
  } state_t;

  state_t             state;
  logic [7:0]         gap_cnt;
  logic [7:0]         half_cnt;
  logic [3:0]         bit_idx;
  logic [2:0]         chan_q;
  logic [2:0]         prev_chan;
  logic               prev_chan_valid;
  logic [11:0]        shift_q;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [15:0]        seq_q;
  logic [11:0]        data_q;
  logic [ACC_W-1:0]   sum;
  logic               accept;

  // Channel address bit driven during bit period idx: DIN carries the channel
  // MSB first in bit periods 2..4 and zero everywhere else.
  function automatic logic addr_bit(input logic [3:0] idx, input logic [2:0] c);
    case (idx)
      4'd2:    return c[2];
      4'd3:    return c[1];
      4'd4:    return c[0];
      default: return 1'b0;
    endcase
  endfunction

  assign raw_depth = {seq_q, 4'h0, data_q};

  // Running sum including the just-received sample, and the pipeline rule: the
  // data in this frame belongs to the previous frame's address, so it is only
  // usable when that frame finished and addressed the same channel.
  always_comb begin
    sum    = acc + ACC_W'(shift_q);
    accept = prev_chan_valid && (prev_chan == chan_q);
  end

  // Frame sequencer, serial shifter and averaging, all with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_GAP;
      gap_cnt         <= '0;
      half_cnt        <= '0;
      bit_idx         <= '0;
      adc_cs_n        <= 1'b1;
      adc_sclk        <= 1'b1;
      adc_saddr       <= 1'b0;
      chan_q          <= '0;
      prev_chan       <= '0;
      prev_chan_valid <= 1'b0;
      shift_q         <= '0;
      acc             <= '0;
      cnt             <= '0;
      seq_q           <= '0;
      data_q          <= '0;
      depth_valid     <= 1'b0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every branch sees
      // the register values from before this edge, independent of statement order.
      depth_valid <= 1'b0;
      case (state)
        S_GAP: begin
          adc_cs_n <= 1'b1;
          adc_sclk <= 1'b1;
          if (gap_cnt == GAP_LAST) begin
            gap_cnt <= '0;
            state   <= S_START;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end

        // Latch the channel for the whole frame and open bit period 0 with the
        // first SCLK falling edge.
        S_START: begin
          chan_q    <= chan;
          adc_cs_n  <= 1'b0;
          adc_sclk  <= 1'b0;
          adc_saddr <= 1'b0;
          bit_idx   <= '0;
          half_cnt  <= '0;
          state     <= S_XFER;
        end

        // adc_sclk itself tells which half of the bit period is running.
        S_XFER: begin
          if (half_cnt == HALF_LAST) begin
            half_cnt <= '0;
            if (!adc_sclk) begin
              adc_sclk <= 1'b1;
              shift_q  <= {shift_q[10:0], adc_sdat};
            end else if (bit_idx == 4'd15) begin
              state <= S_DONE;
            end else begin
              adc_sclk  <= 1'b0;
              bit_idx   <= bit_idx + 4'd1;
              adc_saddr <= addr_bit(bit_idx + 4'd1, chan_q);
            end
          end else begin
            half_cnt <= half_cnt + 8'd1;
          end
        end

        // The 12-bit shifter now holds bits 4..15 of the frame.
        S_DONE: begin
          adc_cs_n        <= 1'b1;
          prev_chan       <= chan_q;
          prev_chan_valid <= 1'b1;
          state           <= S_GAP;
          if (accept) begin
            if (cnt == CNT_LAST) begin
              data_q      <= 12'(sum >> AVG_LOG2);
              seq_q       <= seq_q + 16'd1;
              depth_valid <= 1'b1;
              acc         <= '0;
              cnt         <= '0;
            end else begin
              acc <= sum;
              cnt <= cnt + 1'b1;
            end
          end else begin
            acc <= '0;
            cnt <= '0;
          end
        end

        default: state <= S_GAP;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_depth_sampler.sv
// Self-checking bench for adc_depth_sampler: a frame-level reference model and
// an ADC128S022 behavioural model with its one-frame address pipeline.
module tb_adc_depth_sampler;

  localparam int SH   = 2;
  localparam int GAP  = 2;
  localparam int L2   = 2;
  localparam int N    = 1 << L2;
  localparam int XF   = 32 * SH;        // clks spent shifting one frame
  localparam int P    = GAP + 2 + XF;   // frame period
  localparam int DONE = 1 + XF;         // frame-relative edge that processes the sample

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  chan = 3'd0;
  logic        sdat_drv = 1'b0;
  logic        adc_cs_n, adc_saddr, adc_sclk, depth_valid;
  logic [31:0] raw_depth;

  adc_depth_sampler #(.SCLK_HALF(SH), .GAP_CYCLES(GAP), .AVG_LOG2(L2)) dut (
    .clk         (clk),
    .reset       (rst),
    .chan        (chan),
    .adc_sdat    (sdat_drv),
    .adc_cs_n    (adc_cs_n),
    .adc_saddr   (adc_saddr),
    .adc_sclk    (adc_sclk),
    .raw_depth   (raw_depth),
    .depth_valid (depth_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // Value each channel's sensor currently reads, set by the stimulus.
  logic [11:0] chan_val [8];

  // ADC model: latches its word at CS_N fall using the address captured in the
  // previous frame, shifts a bit out on every SCLK fall, and captures DIN bits
  // 2..4 on SCLK rises.
  logic [2:0]  adc_addr = 3'd0;
  logic [2:0]  adc_addr_sh = 3'd0;
  logic [15:0] adc_word = 16'h0;
  logic        adc_in_frame = 1'b0;
  logic        adc_prev_sclk = 1'b1;
  int          adc_fe = 0;
  int          adc_re = 0;

  always @(negedge clk) begin
    if (adc_cs_n !== 1'b0) begin
      if (adc_in_frame) adc_addr = adc_addr_sh;
      adc_in_frame = 1'b0;
      adc_fe = 0;
      adc_re = 0;
    end else begin
      if (!adc_in_frame) begin
        adc_in_frame = 1'b1;
        adc_word = {4'h0, chan_val[adc_addr]};
      end
      if (adc_prev_sclk && !adc_sclk && adc_fe < 16) begin
        sdat_drv = adc_word[15 - adc_fe];
        adc_fe++;
      end
      if (!adc_prev_sclk && adc_sclk) begin
        if (adc_re >= 2 && adc_re <= 4) adc_addr_sh[4 - adc_re] = adc_saddr;
        adc_re++;
      end
    end
    adc_prev_sclk = adc_sclk;
  end

  // Reference model, advanced per clock edge from frame arithmetic.
  int          cyc = -2;              // edges since reset release; -2 before first reset
  logic [2:0]  m_cur_chan = 3'd0;
  logic [2:0]  m_last_chan = 3'd0;
  logic [2:0]  m_prev_chan = 3'd0;
  logic        m_prev_valid = 1'b0;
  logic [11:0] m_cur_sample = 12'h0;
  int          m_acc = 0;
  int          m_cnt = 0;
  logic [15:0] m_seq = 16'h0;
  logic [11:0] m_data = 12'h0;
  logic        m_valid = 1'b0;
  int          seq_force_req = 0;
  int          seq_force_seen = 0;
  logic        force_active = 1'b0;

  always @(posedge clk) begin
    m_valid = 1'b0;
    if (rst) begin
      cyc          = -1;
      m_prev_valid = 1'b0;
      m_acc        = 0;
      m_cnt        = 0;
      m_seq        = 16'h0;
      m_data       = 12'h0;
    end else if (cyc != -2) begin
      cyc++;
      if (cyc >= GAP) begin
        if ((cyc - GAP) % P == 0) begin
          m_cur_chan   = chan;
          m_cur_sample = chan_val[m_last_chan];
          m_last_chan  = chan;
        end
        if ((cyc - GAP) % P == DONE) begin
          if (m_prev_valid && m_prev_chan == m_cur_chan) begin
            m_acc += int'(m_cur_sample);
            m_cnt++;
            if (m_cnt == N) begin
              m_data  = 12'(m_acc / N);
              m_seq   = m_seq + 16'd1;
              m_valid = 1'b1;
              m_acc   = 0;
              m_cnt   = 0;
            end
          end else begin
            m_acc = 0;
            m_cnt = 0;
          end
          m_prev_chan  = m_cur_chan;
          m_prev_valid = 1'b1;
        end
      end
    end
    if (force_active) begin
      release dut.seq_q;
      force_active = 1'b0;
    end else if (seq_force_req != seq_force_seen) begin
      seq_force_seen = seq_force_req;
      force dut.seq_q = 16'hFFFF;
      m_seq = 16'hFFFF;
      force_active = 1'b1;
    end
  end

  function automatic logic abit(input int b, input logic [2:0] c);
    return (b >= 2 && b <= 4) ? c[4 - b] : 1'b0;
  endfunction

  // Compare process: every cycle once reset has been applied.
  logic exp_cs, exp_sclk, exp_saddr;
  int   ph;
  always @(negedge clk) begin
    if (cyc != -2) begin
      if (cyc < GAP) begin
        exp_cs = 1'b1; exp_sclk = 1'b1; exp_saddr = 1'b0;
      end else begin
        ph        = (cyc - GAP) % P;
        exp_cs    = (ph <= XF) ? 1'b0 : 1'b1;
        exp_sclk  = (ph < XF) ? (((ph / SH) % 2) == 1) : 1'b1;
        exp_saddr = (ph < XF) ? abit(ph / (2 * SH), m_cur_chan) : 1'b0;
      end
      check("cs_n",        32'(adc_cs_n),    32'(exp_cs));
      check("sclk",        32'(adc_sclk),    32'(exp_sclk));
      check("saddr",       32'(adc_saddr),   32'(exp_saddr));
      check("depth_valid", 32'(depth_valid), 32'(m_valid));
      check("raw_depth",   raw_depth,        {m_seq, 4'h0, m_data});
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
  endtask

  // Wait for the next negedge that follows frame-relative edge p.
  task automatic wait_phase(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(cyc >= GAP && (cyc - GAP) % P == p) && n < 400);
    if (n >= 400) timeout_fail("wait_phase");
  endtask

  task automatic wait_pulse(input string name, input logic [31:0] exp);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (depth_valid !== 1'b1 && n < 1000);
    if (depth_valid !== 1'b1) timeout_fail(name);
    else check(name, raw_depth, exp);
  endtask

  task automatic measure_frame();
    int   t = 0, t0 = -1, t1 = -1, falls = 0;
    logic pc, ps;
    pc = adc_cs_n;
    ps = adc_sclk;
    while (t < 300 && t1 < 0) begin
      @(negedge clk);
      t++;
      if (pc && !adc_cs_n) begin
        if (t0 < 0) t0 = t;
        else t1 = t;
      end
      if (t0 >= 0 && t1 < 0 && !adc_cs_n && ps && !adc_sclk) falls++;
      pc = adc_cs_n;
      ps = adc_sclk;
    end
    check("frame period", 32'(t1 - t0), 32'd68);
    check("sclk periods with cs_n low", 32'(falls), 32'd16);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1);
  end

  initial begin
    logic [11:0] vals2 [4];
    logic [11:0] vals4 [4];
    vals2 = '{12'd101, 12'd102, 12'd103, 12'd4095};
    vals4 = '{12'd1000, 12'd1001, 12'd1002, 12'd1005};
    for (int c = 0; c < 8; c++) chan_val[c] = 12'(c * 16 + 7);

    // 1: constant 0xABC, first frame discarded, pulse after five frames.
    chan = 3'd0;
    chan_val[0] = 12'hABC;
    do_reset();
    check("reset raw_depth", raw_depth, 32'h0);
    check("reset cs_n", 32'(adc_cs_n), 32'd1);
    wait_pulse("t1 first average", 32'h0001_0ABC);

    // 2: 100..103 then 4095 x4.
    chan_val[0] = 12'd100;
    do_reset();
    wait_phase(30);
    for (int i = 0; i < 4; i++) begin
      wait_phase(30);
      chan_val[0] = vals2[i];
    end
    wait_pulse("t2 avg 100..103", 32'h0001_0065);
    wait_pulse("t2 full scale", 32'h0002_0FFF);

    // 3: pins with chan 5.
    wait_phase(30);
    chan = 3'd5;
    chan_val[5] = 12'h5A5;
    measure_frame();

    // 4: channel change after two accepted samples.
    chan = 3'd0;
    chan_val[0] = 12'd200;
    do_reset();
    wait_phase(30);
    wait_phase(30);
    wait_phase(30);
    chan = 3'd5;
    for (int i = 0; i < 4; i++) begin
      wait_phase(30);
      chan_val[5] = vals4[i];
    end
    wait_pulse("t4 channel 5 average", 32'h0001_03EA);

    // 5: reset during bit 7 of a frame.
    chan = 3'd0;
    chan_val[0] = 12'h123;
    do_reset();
    wait_pulse("t5 before abort", 32'h0001_0123);
    wait_phase(29);
    rst = 1'b1;
    @(negedge clk);
    check("abort cs_n", 32'(adc_cs_n), 32'd1);
    check("abort sclk", 32'(adc_sclk), 32'd1);
    check("abort raw_depth", raw_depth, 32'h0);
    rst = 1'b0;
    chan_val[0] = 12'h456;
    wait_pulse("t5 after abort", 32'h0001_0456);

    // 6: sequence count wraps without touching the data field.
    chan_val[0] = 12'h7E5;
    do_reset();
    wait_phase(30);
    wait_phase(30);
    seq_force_req++;
    wait_pulse("t6 seq wrap", 32'h0000_07E5);

    // Randomized run, including one reset at a random point in a frame.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        wait_phase($urandom_range(1, 60));
        do_reset();
      end
      wait_phase(30);
      if ($urandom_range(0, 3) == 0) chan = 3'($urandom_range(0, 7));
      for (int c = 0; c < 8; c++) chan_val[c] = 12'($urandom_range(0, 4095));
    end
    repeat (P) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
